// File: rtl/intra16_res_ctrl_pkg.sv
// Shared constants, state encoding and the residual helper for the
// 16x16 intra residual controller.
package intra16_pkg;

  localparam int ROWS  = 16;
  localparam int PIX   = 16;
  localparam int SAD_W = 16;
  localparam int ROW_W = 128;

  localparam logic [SAD_W-1:0] SAD_MAX = 16'hFFFF;

  localparam logic [1:0] MODE_V  = 2'd0;
  localparam logic [1:0] MODE_H  = 2'd1;
  localparam logic [1:0] MODE_DC = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SAD      = 3'd1,
    ST_SAD_LAST = 3'd2,
    ST_DECIDE   = 3'd3,
    ST_RES_RD   = 3'd4,
    ST_RES_WAIT = 3'd5,
    ST_RES_OUT  = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  // Per-pixel (mb - pred) mod 256; the 8-bit wrap is the intended residual.
  function automatic logic [ROW_W-1:0] row_residual(input logic [ROW_W-1:0] mb,
                                                    input logic [ROW_W-1:0] pred);
    logic [ROW_W-1:0] res;
    res = '0;
    for (int i = 0; i < PIX; i++) begin
      res[i*8 +: 8] = mb[i*8 +: 8] - pred[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/intra16_res_ctrl_if.sv
// Residual row stream toward the forward transform (valid/ready).
interface intra16_res_ctrl_if;
  import intra16_pkg::*;

  logic [ROW_W-1:0] res_row;
  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_idx;

  modport master (output res_row, output res_valid, output res_idx, input res_ready);
  modport slave  (input res_row, input res_valid, input res_idx, output res_ready);
endinterface

// File: rtl/intra16_res_ctrl_row_sad16.sv
// Combinational sum of absolute differences over one 16-pixel row.
module row_sad16
  import intra16_pkg::*;
(
  input  logic [ROW_W-1:0] a,
  input  logic [ROW_W-1:0] b,
  output logic [11:0]      sad
);

  logic [11:0]       sum_s;
  logic signed [8:0] diff_s;
  logic [7:0]        absd_s;

  // 9-bit signed difference per pixel, magnitude folded into a 12-bit sum.
  always_comb begin
    sum_s  = 12'd0;
    diff_s = 9'sd0;
    absd_s = 8'd0;
    for (int i = 0; i < PIX; i++) begin
      diff_s = $signed({1'b0, a[i*8 +: 8]}) - $signed({1'b0, b[i*8 +: 8]});
      if (diff_s[8]) begin
        absd_s = 8'(-diff_s);
      end else begin
        absd_s = 8'(diff_s);
      end
      sum_s = sum_s + {4'd0, absd_s};
    end
    sad = sum_s;
  end

endmodule

// File: rtl/intra16_res_ctrl.sv
// Two-pass 16x16 intra scheduler: pass 1 picks the cheapest allowed mode
// by SAD, pass 2 streams residual rows of that mode to the transform.
module intra16_res_ctrl
  import intra16_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  avail_top,
  input  logic                  avail_left,
  output logic                  rd_en,
  output logic [3:0]            rd_row,
  input  logic [ROW_W-1:0]      mb_row,
  input  logic [ROW_W-1:0]      vpred_row,
  input  logic [ROW_W-1:0]      hpred_row,
  input  logic [ROW_W-1:0]      dcpred_row,
  intra16_res_ctrl_if.master    res,
  output logic [1:0]            best_mode,
  output logic [SAD_W-1:0]      best_sad,
  output logic                  busy,
  output logic                  done
);

  state_t           state_r, state_nx;
  logic [3:0]       cnt_r, cnt_nx;
  logic             top_ok_r, left_ok_r;
  logic [SAD_W-1:0] acc_v_r, acc_h_r, acc_dc_r;
  logic [11:0]      sad_v_s, sad_h_s, sad_dc_s;
  logic [SAD_W-1:0] eff_v_s, eff_h_s;
  logic [1:0]       dec_mode_s;
  logic [SAD_W-1:0] dec_sad_s;
  logic [ROW_W-1:0] pred_sel_s;
  logic             acc_en_s;

  row_sad16 u_sad_v  (.a(mb_row), .b(vpred_row),  .sad(sad_v_s));
  row_sad16 u_sad_h  (.a(mb_row), .b(hpred_row),  .sad(sad_h_s));
  row_sad16 u_sad_dc (.a(mb_row), .b(dcpred_row), .sad(sad_dc_s));

  // Row data returns one cycle after its read, so row 0 lands when cnt is 1.
  assign acc_en_s = ((state_r == ST_SAD) && (cnt_r != 4'd0)) || (state_r == ST_SAD_LAST);

  // Next-state and row counter sequencing.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_SAD;
          cnt_nx   = 4'd0;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SAD: begin
        cnt_nx = cnt_r + 4'd1;
        if (cnt_r == 4'd15) begin
          state_nx = ST_SAD_LAST;
        end else begin
          state_nx = ST_SAD;
        end
      end
      ST_SAD_LAST: state_nx = ST_DECIDE;
      ST_DECIDE: begin
        cnt_nx   = 4'd0;
        state_nx = ST_RES_RD;
      end
      ST_RES_RD:   state_nx = ST_RES_WAIT;
      ST_RES_WAIT: state_nx = ST_RES_OUT;
      ST_RES_OUT: begin
        if (res.res_ready) begin
          if (cnt_r == 4'd15) begin
            state_nx = ST_DONE;
          end else begin
            cnt_nx   = cnt_r + 4'd1;
            state_nx = ST_RES_RD;
          end
        end else begin
          state_nx = ST_RES_OUT;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Mode decision: disabled modes cost SAD_MAX, which no real SAD reaches; ties favour lower mode.
  always_comb begin
    eff_v_s = top_ok_r  ? acc_v_r : SAD_MAX;
    eff_h_s = left_ok_r ? acc_h_r : SAD_MAX;
    if ((eff_v_s <= eff_h_s) && (eff_v_s <= acc_dc_r)) begin
      dec_mode_s = MODE_V;
      dec_sad_s  = eff_v_s;
    end else if (eff_h_s <= acc_dc_r) begin
      dec_mode_s = MODE_H;
      dec_sad_s  = eff_h_s;
    end else begin
      dec_mode_s = MODE_DC;
      dec_sad_s  = acc_dc_r;
    end
  end

  // Prediction row of the chosen mode for the residual pass.
  always_comb begin
    case (best_mode)
      MODE_V:  pred_sel_s = vpred_row;
      MODE_H:  pred_sel_s = hpred_row;
      default: pred_sel_s = dcpred_row;
    endcase
  end

  // State, counter and neighbour availability latched at start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      top_ok_r  <= 1'b0;
      left_ok_r <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      if ((state_r == ST_IDLE) && start) begin
        top_ok_r  <= avail_top;
        left_ok_r <= avail_left;
      end
    end
  end

  // Per-mode SAD accumulators, cleared when a macroblock is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_v_r  <= 16'd0;
      acc_h_r  <= 16'd0;
      acc_dc_r <= 16'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      acc_v_r  <= 16'd0;
      acc_h_r  <= 16'd0;
      acc_dc_r <= 16'd0;
    end else if (acc_en_s) begin
      acc_v_r  <= acc_v_r  + {4'd0, sad_v_s};
      acc_h_r  <= acc_h_r  + {4'd0, sad_h_s};
      acc_dc_r <= acc_dc_r + {4'd0, sad_dc_s};
    end
  end

  // Decision result and residual row registers; both hold until reloaded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_mode   <= 2'd0;
      best_sad    <= 16'd0;
      res.res_row <= '0;
      res.res_idx <= 4'd0;
    end else begin
      if (state_r == ST_DECIDE) begin
        best_mode <= dec_mode_s;
        best_sad  <= dec_sad_s;
      end
      if (state_r == ST_RES_WAIT) begin
        res.res_row <= row_residual(mb_row, pred_sel_s);
        res.res_idx <= cnt_r;
      end
    end
  end

  // Strobes decoded from the next state so they align with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en         <= 1'b0;
      rd_row        <= 4'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      res.res_valid <= 1'b0;
    end else begin
      rd_en         <= (state_nx == ST_SAD) || (state_nx == ST_RES_RD);
      rd_row        <= cnt_nx;
      busy          <= (state_nx != ST_IDLE);
      done          <= (state_nx == ST_DONE);
      res.res_valid <= (state_nx == ST_RES_OUT);
    end
  end

endmodule

// File: tb/tb_intra16_res_ctrl.sv
// Directed bench for intra16_res_ctrl with a frame-level reference model.
module tb_intra16_res_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         avail_top = 1'b0;
  logic         avail_left = 1'b0;
  logic         rd_en;
  logic [3:0]   rd_row;
  logic [127:0] mb_row, vpred_row, hpred_row, dcpred_row;
  logic [1:0]   best_mode;
  logic [15:0]  best_sad;
  logic         busy, done;

  intra16_res_ctrl_if res_if();

  intra16_res_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .avail_top(avail_top), .avail_left(avail_left),
    .rd_en(rd_en), .rd_row(rd_row),
    .mb_row(mb_row), .vpred_row(vpred_row), .hpred_row(hpred_row), .dcpred_row(dcpred_row),
    .res(res_if.master),
    .best_mode(best_mode), .best_sad(best_sad), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Macroblock and prediction buffers, pixel [row][col]
  logic [7:0] mbm[16][16], vpm[16][16], hpm[16][16], dpm[16][16];

  // Model results
  int            m_sad[3];
  int            exp_mode, exp_sad;
  logic [131:0]  exp_q[$];
  logic [127:0]  last_row;

  task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_row(input int kind, input int r);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0: v[i*8 +: 8] = mbm[r][i];
        1: v[i*8 +: 8] = vpm[r][i];
        2: v[i*8 +: 8] = hpm[r][i];
        default: v[i*8 +: 8] = dpm[r][i];
      endcase
    end
    return v;
  endfunction

  // Buffer: data for a read appears on the cycle after rd_en
  always @(posedge clk) begin
    if (rd_en) begin
      mb_row     <= pack_row(0, int'(rd_row));
      vpred_row  <= pack_row(1, int'(rd_row));
      hpred_row  <= pack_row(2, int'(rd_row));
      dcpred_row <= pack_row(3, int'(rd_row));
    end
  end

  task automatic fill_flat(input int m, input int v, input int h, input int d);
    for (int r = 0; r < 16; r++)
      for (int i = 0; i < 16; i++) begin
        mbm[r][i] = 8'(m); vpm[r][i] = 8'(v); hpm[r][i] = 8'(h); dpm[r][i] = 8'(d);
      end
  endtask

  task automatic fill_var(input int seed);
    for (int r = 0; r < 16; r++)
      for (int i = 0; i < 16; i++) begin
        mbm[r][i] = 8'(r*37 + i*11 + seed);
        vpm[r][i] = 8'(r*5 + i*19 + seed*3);
        hpm[r][i] = 8'(255 - r*9 - i);
        dpm[r][i] = 8'(128 + i*2 - r);
      end
  endtask

  // Whole-macroblock reference: SAD per mode, selection, residual list
  task automatic model_mb(input logic at, input logic al);
    int eff[3];
    int d;
    logic [127:0] row;
    for (int m = 0; m < 3; m++) begin
      m_sad[m] = 0;
      for (int r = 0; r < 16; r++)
        for (int i = 0; i < 16; i++) begin
          case (m)
            0: d = int'(mbm[r][i]) - int'(vpm[r][i]);
            1: d = int'(mbm[r][i]) - int'(hpm[r][i]);
            default: d = int'(mbm[r][i]) - int'(dpm[r][i]);
          endcase
          m_sad[m] += (d < 0) ? -d : d;
        end
    end
    eff[0] = at ? m_sad[0] : 65535;
    eff[1] = al ? m_sad[1] : 65535;
    eff[2] = m_sad[2];
    exp_mode = 0;
    for (int m = 1; m < 3; m++) if (eff[m] < eff[exp_mode]) exp_mode = m;
    exp_sad = eff[exp_mode];
    exp_q.delete();
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 16; i++) begin
        case (exp_mode)
          0: row[i*8 +: 8] = mbm[r][i] - vpm[r][i];
          1: row[i*8 +: 8] = mbm[r][i] - hpm[r][i];
          default: row[i*8 +: 8] = mbm[r][i] - dpm[r][i];
        endcase
      end
      exp_q.push_back({4'(r), row});
    end
  endtask

  // Compare process: residual stream, stall stability, no reads while pending, result at done
  logic [127:0] prev_row;
  logic [3:0]   prev_idx;
  logic         prev_stall = 1'b0;
  logic [131:0] e;

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (res_if.res_valid) begin
        check("no_read_while_pending", {131'd0, rd_en}, 132'd0);
        if (prev_stall) begin
          check("stall_row_stable", {4'd0, res_if.res_row}, {4'd0, prev_row});
          check("stall_idx_stable", {128'd0, res_if.res_idx}, {128'd0, prev_idx});
        end
        if (res_if.res_ready) begin
          prev_stall = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_row", {res_if.res_idx, res_if.res_row}, 132'd0);
          end else begin
            e = exp_q.pop_front();
            check("res_row_idx", {res_if.res_idx, res_if.res_row}, e);
            last_row = res_if.res_row;
          end
        end else begin
          prev_stall = 1'b1;
          prev_row   = res_if.res_row;
          prev_idx   = res_if.res_idx;
        end
      end else begin
        prev_stall = 1'b0;
      end
      if (done) begin
        check("rows_left_at_done", 132'(exp_q.size()), 132'd0);
        check("best_mode", {130'd0, best_mode}, 132'(exp_mode));
        check("best_sad", {116'd0, best_sad}, 132'(exp_sad));
      end
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_row"}, {4'd0, res_if.res_row}, 132'd0);
    check({name, "_ctl"}, {102'd0, rd_en, rd_row, res_if.res_valid, res_if.res_idx,
                           best_mode, best_sad, busy, done}, 132'd0);
  endtask

  // One macroblock: optional 5-cycle stall on a row, a stray start pulse, or an abort by reset
  task automatic run_mb(input logic at, input logic al, input int stall_row,
                        input int inject_k, input int abort_row, input int exp_done_k);
    int stalls;
    int done_k;
    logic aborted;
    model_mb(at, al);
    stalls = 0; done_k = -1; aborted = 1'b0;
    @(negedge clk);
    start = 1'b1; avail_top = at; avail_left = al; res_if.res_ready = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start = (k == inject_k);
      avail_top  = (k == inject_k) ? 1'b0 : at;
      avail_left = (k == inject_k) ? 1'b0 : al;
      if (stall_row >= 0 && res_if.res_valid && int'(res_if.res_idx) == stall_row && stalls < 5) begin
        res_if.res_ready = 1'b0;
        stalls++;
      end else begin
        res_if.res_ready = 1'b1;
      end
      if (abort_row >= 0 && rd_en && int'(rd_row) == abort_row && k < 18) begin
        reset = 1'b0;
        #1;
        check_all_zero("reset_abort");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (done) begin
        done_k = k;
        break;
      end
    end
    if (aborted) begin
      repeat (30) begin
        @(negedge clk);
        #1;
        if (res_if.res_valid || busy) begin
          check("activity_after_abort", {130'd0, res_if.res_valid, busy}, 132'd0);
        end
      end
    end else begin
      check("done_cycle", 132'(done_k), 132'(exp_done_k));
      start = 1'b0;
      @(negedge clk);
      #1;
      check("idle_after_done", {130'd0, busy, done}, 132'd0);
    end
  endtask

  initial begin
    res_if.res_ready = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    reset = 1'b1;

    // Flat: V exact, H and DC 10 off each
    fill_flat(100, 100, 90, 110);
    run_mb(1'b1, 1'b1, -1, 0, -1, 67);
    check("pin_model_sad_v", 132'(m_sad[0]), 132'd0);
    check("pin_model_sad_h", 132'(m_sad[1]), 132'd2560);
    check("pin_model_sad_dc", 132'(m_sad[2]), 132'd2560);
    check("t1_best_mode", {130'd0, best_mode}, 132'd0);
    check("t1_best_sad", {116'd0, best_sad}, 132'd0);
    check("t1_last_row", {4'd0, last_row}, 132'd0);

    // V/H tie goes to V, residual wraps to 0xF6
    fill_flat(50, 60, 40, 200);
    run_mb(1'b1, 1'b1, -1, 0, -1, 67);
    check("pin_model_sad_dc2", 132'(m_sad[2]), 132'd38400);
    check("t2_best_mode", {130'd0, best_mode}, 132'd0);
    check("t2_best_sad", {116'd0, best_sad}, 132'd2560);
    check("t2_last_row", {4'd0, last_row}, {4'd0, {16{8'hF6}}});

    // Top unavailable: DC (1280) beats H (2560)
    fill_flat(100, 100, 90, 95);
    run_mb(1'b0, 1'b1, -1, 0, -1, 67);
    check("t3_best_mode", {130'd0, best_mode}, 132'd2);
    check("t3_best_sad", {116'd0, best_sad}, 132'd1280);

    // Both neighbours missing: DC forced even though V would be exact
    fill_flat(100, 100, 100, 120);
    run_mb(1'b0, 1'b0, -1, 0, -1, 67);
    check("t4_best_mode", {130'd0, best_mode}, 132'd2);
    check("t4_best_sad", {116'd0, best_sad}, 132'd5120);

    // Varied pixels, 5-cycle stall on row 7
    fill_var(3);
    run_mb(1'b1, 1'b1, 7, 0, -1, 72);

    // Abort in SAD at row 9, then a clean full run
    fill_var(17);
    run_mb(1'b1, 1'b1, -1, 0, 9, 0);
    run_mb(1'b1, 1'b0, -1, 0, -1, 67);

    // Stray start while busy is ignored
    fill_var(41);
    run_mb(1'b1, 1'b1, -1, 30, -1, 67);
    repeat (4) begin
      @(negedge clk);
      #1;
      check("no_restart", {131'd0, busy}, 132'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
